// File: rtl/maze_view_scanner.sv
// Walks an N x N maze grid in view order and streams one map-memory index per beat.
// Define MAZE_VIEW_MIRROR_EN to add a mirror input that flips view x before the mapping.
module maze_view_scanner #(
  parameter int unsigned SIZE = 22,
  localparam int unsigned CW = $clog2(SIZE),
  localparam int unsigned IW = $clog2(SIZE * SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [1:0]    direction_i,
`ifdef MAZE_VIEW_MIRROR_EN
  input  logic          mirror_i,
`endif
  input  logic          abort_i,
  output logic          busy_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] out_index_o,
  output logic [CW-1:0] out_x_o,
  output logic [CW-1:0] out_y_o,
  output logic          out_last_o,
  output logic          done_o
);

  typedef enum logic [1:0] {StIdle, StScan, StFlush} state_e;

  localparam logic [CW-1:0] MaxC  = CW'(SIZE - 1);
  localparam logic [IW-1:0] SideI = IW'(SIZE);

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic          mir_q, mir_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [IW-1:0] index_q, index_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;

  logic [CW-1:0] mx, row, col;
  logic [IW-1:0] cell_index;
  logic          cell_last;

  // Map the current view cell to its linear map-memory index.
  always_comb begin
    mx = x_q;
    if (mir_q) begin
      mx = MaxC - x_q;
    end
    row = y_q;
    col = mx;
    case (dir_q)
      2'd0: begin row = y_q;         col = mx;          end
      2'd1: begin row = mx;          col = MaxC - y_q;  end
      2'd2: begin row = MaxC - y_q;  col = MaxC - mx;   end
      default: begin row = MaxC - mx; col = y_q;        end
    endcase
    cell_index = IW'(row) * SideI + IW'(col);
    cell_last  = (x_q == MaxC) && (y_q == MaxC);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mir_d   = mir_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    index_d = index_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    unique case (state_q)
      StIdle: begin
        // The done cycle still belongs to the previous scan, so start waits one more cycle.
        if (start_i && !abort_i && !done_q) begin
          dir_d   = direction_i;
`ifdef MAZE_VIEW_MIRROR_EN
          mir_d   = mirror_i;
`else
          mir_d   = 1'b0;
`endif
          x_d     = '0;
          y_d     = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (!valid_q || out_ready_i) begin
          valid_d = 1'b1;
          index_d = cell_index;
          ox_d    = x_q;
          oy_d    = y_q;
          last_d  = cell_last;
          if (cell_last) begin
            state_d = StFlush;
          end else if (x_q == MaxC) begin
            x_d = '0;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      StFlush: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dir_q   <= 2'd0;
      mir_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      mir_q   <= mir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      index_q <= index_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = valid_q;
  assign out_index_o = index_q;
  assign out_x_o     = ox_q;
  assign out_y_o     = oy_q;
  assign out_last_o  = last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_maze_view_scanner.sv
// Scoreboard bench for maze_view_scanner: stimulus queues expected beats, monitors pop on handshake.
`timescale 1ns/1ps
module tb_maze_view_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 0, abort4 = 0, ready4 = 1;
  logic [1:0] dir4 = 0;
  logic       busy4, valid4, last4, done4;
  logic [3:0] idx4;
  logic [1:0] x4, y4;

  logic       start22 = 0, abort22 = 0, ready22 = 1;
  logic [1:0] dir22 = 0;
  logic       busy22, valid22, last22, done22;
  logic [8:0] idx22;
  logic [4:0] x22, y22;

`ifdef MAZE_VIEW_MIRROR_EN
  logic mirror4 = 0, mirror22 = 0;
`endif

  maze_view_scanner #(.SIZE(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .direction_i(dir4),
`ifdef MAZE_VIEW_MIRROR_EN
    .mirror_i(mirror4),
`endif
    .abort_i(abort4), .busy_o(busy4), .out_valid_o(valid4), .out_ready_i(ready4),
    .out_index_o(idx4), .out_x_o(x4), .out_y_o(y4), .out_last_o(last4), .done_o(done4)
  );

  maze_view_scanner #(.SIZE(22)) u_dut22 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start22), .direction_i(dir22),
`ifdef MAZE_VIEW_MIRROR_EN
    .mirror_i(mirror22),
`endif
    .abort_i(abort22), .busy_o(busy22), .out_valid_o(valid22), .out_ready_i(ready22),
    .out_index_o(idx22), .out_x_o(x22), .out_y_o(y22), .out_last_o(last22), .done_o(done22)
  );

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed SIZE=4 index sequences in view order, one row per direction.
  localparam int T4 [4][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12},
    '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
    '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3}
  };
  localparam int T4M0 [16] = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8, 15, 14, 13, 12};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pack(input int idx, input int x, input int y, input int lst);
    return (idx << 16) | (x << 8) | (y << 1) | lst;
  endfunction

  function automatic int m22(input int d, input int x, input int y);
    case (d)
      0: return y * 22 + x;
      1: return x * 22 + (21 - y);
      2: return (21 - y) * 22 + (21 - x);
      default: return (21 - x) * 22 + y;
    endcase
  endfunction

  int q4[$];
  int q22[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the SIZE=4 instance.
  int  beats4 = 0, busy_cyc4 = 0, done_cnt4 = 0, done_cyc4 = 0, last_hs4 = 0;
  int  hold4 = 0;
  bit  stall4 = 0;
  always @(negedge clk) begin : mon4
    int got;
    got = pack(idx4, x4, y4, last4);
    if (busy4) busy_cyc4++;
    if (done4) begin
      done_cnt4++;
      done_cyc4 = cyc;
    end
    if (valid4 && stall4) check("hold4", got, hold4);
    stall4 = valid4 && !ready4;
    hold4  = got;
    if (valid4 && ready4) begin
      beats4++;
      if (last4) last_hs4 = cyc;
      if (q4.size() == 0) check("extra_beat4", got, -1);
      else check("beat4", got, q4.pop_front());
    end
  end

  // Monitor for the SIZE=22 instance.
  int  beats22 = 0, done_cnt22 = 0, first_idx22 = -1, last_idx22 = -1;
  int  hold22 = 0;
  bit  stall22 = 0;
  always @(negedge clk) begin : mon22
    int got;
    got = pack(idx22, x22, y22, last22);
    if (done22) done_cnt22++;
    if (valid22 && stall22) check("hold22", got, hold22);
    stall22 = valid22 && !ready22;
    hold22  = got;
    if (valid22 && ready22) begin
      if (x22 == 0 && y22 == 0) first_idx22 = int'(idx22);
      if (last22) last_idx22 = int'(idx22);
      beats22++;
      check("range22", int'(idx22 <= 9'd483), 1);
      if (q22.size() == 0) check("extra_beat22", got, -1);
      else check("beat22", got, q22.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int d, input bit mir);
    for (int i = 0; i < 16; i++) begin
      q4.push_back(pack(mir ? T4M0[i] : T4[d][i], i % 4, i / 4, int'(i == 15)));
    end
  endtask

  task automatic push22(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      q22.push_back(pack(m22(d, i % 22, i / 22), i % 22, i / 22, int'(i == 483)));
    end
  endtask

  task automatic wait_done4(input int limit, input bit toggle, input string name);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      ready4 = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done4) seen = 1;
    end
    ready4 = 1'b1;
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic wait_done22(input int limit, input bit toggle, input string name);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      ready22 = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done22) seen = 1;
    end
    ready22 = 1'b1;
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic wait_beats22(input int n, input string name);
    int g = 0;
    while (beats22 < n && g < 200) begin
      tick();
      g++;
    end
    check({name, "_beats_reached"}, int'(beats22 >= n), 1);
  endtask

  int b0, c0, d0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy4, 0);
    check("rst_valid", valid4, 0);
    check("rst_done_last", {done4, last4}, 0);
    check("rst_out4", pack(idx4, x4, y4, 0), 0);
    rst_n = 1'b1;
    tick();

    // dir 0, ready held high: latency, throughput, busy span, done placement.
    b0 = beats4; c0 = busy_cyc4; d0 = done_cnt4;
    push4(0, 0);
    dir4 = 2'd0; start4 = 1; tick(); start4 = 0;
    check("t1_busy_rise", busy4, 1);
    check("t1_valid_before_load", valid4, 0);
    tick();
    check("t1_valid_first", valid4, 1);
    wait_done4(60, 0, "t1");
    check("t1_busy_in_done", busy4, 0);
    start4 = 1; tick(); start4 = 0;
    check("t1_start_at_done_ignored", busy4, 0);
    tick();
    check("t1_beats", beats4 - b0, 16);
    check("t1_busy_cycles", busy_cyc4 - c0, 17);
    check("t1_done_pulses", done_cnt4 - d0, 1);
    check("t1_done_after_last", done_cyc4, last_hs4 + 1);

    // dir 1 with direction change and start pulses mid-scan (both ignored).
    push4(1, 0);
    dir4 = 2'd1; start4 = 1; tick(); start4 = 0;
    repeat (3) tick();
    dir4 = 2'd2; start4 = 1; repeat (2) tick(); start4 = 0;
    wait_done4(60, 0, "t2");
    tick();

    // dir 2 and dir 3 with a stalling consumer.
    push4(2, 0);
    dir4 = 2'd2; start4 = 1; tick(); start4 = 0;
    wait_done4(300, 1, "t3");
    tick();
    push4(3, 0);
    dir4 = 2'd3; start4 = 1; tick(); start4 = 0;
    wait_done4(300, 1, "t4");
    tick();

    // start and abort together in IDLE: no scan.
    start4 = 1; abort4 = 1; tick(); start4 = 0; abort4 = 0;
    check("t_start_abort_busy", busy4, 0);
    tick();
    check("t_start_abort_valid", valid4, 0);

`ifdef MAZE_VIEW_MIRROR_EN
    push4(0, 1);
    dir4 = 2'd0; mirror4 = 1; start4 = 1; tick(); start4 = 0; mirror4 = 0;
    wait_done4(60, 0, "tm");
    tick();
`endif

    // SIZE=22, dir 0, random backpressure.
    b0 = beats22;
    push22(0, 484);
    dir22 = 2'd0; start22 = 1; tick(); start22 = 0;
    wait_done22(4000, 1, "t5");
    tick();
    check("t5_beats", beats22 - b0, 484);
    check("t5_last_index", last_idx22, 483);

    // Abort after 5 beats.
    b0 = beats22; d0 = done_cnt22;
    push22(0, 5);
    dir22 = 2'd0; start22 = 1; tick(); start22 = 0;
    wait_beats22(b0 + 5, "t6");
    ready22 = 0; abort22 = 1; tick(); abort22 = 0;
    check("t6_valid_after_abort", valid22, 0);
    check("t6_busy_after_abort", busy22, 0);
    repeat (4) tick();
    ready22 = 1;
    tick();
    check("t6_no_done", done_cnt22 - d0, 0);
    check("t6_beats", beats22 - b0, 5);

    // Reset pulse after 7 beats.
    b0 = beats22; d0 = done_cnt22;
    push22(0, 7);
    dir22 = 2'd0; start22 = 1; tick(); start22 = 0;
    wait_beats22(b0 + 7, "t7");
    ready22 = 0; rst_n = 0; #1;
    check("t7_valid_async", valid22, 0);
    check("t7_busy_async", busy22, 0);
    check("t7_out_async", pack(idx22, x22, y22, last22), 0);
    tick();
    rst_n = 1;
    tick();
    ready22 = 1;
    tick();
    check("t7_no_done", done_cnt22 - d0, 0);
    check("t7_beats", beats22 - b0, 7);

    // Fresh dir 2 scan after the interrupted ones.
    first_idx22 = -1;
    push22(2, 484);
    dir22 = 2'd2; start22 = 1; tick(); start22 = 0;
    wait_done22(1000, 0, "t8");
    tick();
    check("t8_first_index", first_idx22, 483);
    check("t8_last_index", last_idx22, 0);

    check("q4_drained", q4.size(), 0);
    check("q22_drained", q22.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
